// File: rtl/clock_phase_controller.sv
// clock_phase_controller: machine-cycle sequencer for the slow CPU clock.
// Divides clock_in by a runtime-loadable divisor D into a LOW phase of
// floor(D/2) clocks and a HIGH phase of the remainder. It adds run, halt and
// single-step control, and produces one-clock phase_read/phase_write enables.
module clock_phase_controller #(
    parameter logic [27:0] DIVISOR = 28'd50000000
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        run,
    input  logic        halt_req,
    input  logic        step_in,
    input  logic        div_load,
    input  logic [27:0] div_value,
    output logic        clock_out,
    output logic        phase_read,
    output logic        phase_write,
    output logic        running,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [27:0] count_reg, count_next;
    logic [27:0] div_reg, div_next;
    logic [27:0] pend_reg, pend_next;
    logic        pend_valid_reg, pend_valid_next;
    logic        stop_reg, stop_next;
    logic        single_reg, single_next;
    // Set when a halt ends a cycle. While it is set, a held-high run does not
    // restart the machine; run must drop to 0 first.
    logic        halted_reg, halted_next;
    logic        clock_out_reg, clock_out_next;
    logic        phase_read_reg, phase_read_next;
    logic        phase_write_reg, phase_write_next;
    logic [15:0] cycle_count_reg, cycle_count_next;

    logic [1:0]  step_sync_reg;
    logic        step_prev_reg;
    logic        step_edge;

    logic [27:0] low_len, high_len, pend_clamped, start_div;
    logic        low_done, high_done, stop_now;

    assign step_edge    = step_sync_reg[1] & ~step_prev_reg;
    assign low_len      = div_reg >> 1;
    assign high_len     = div_reg - low_len;
    assign low_done     = (count_reg == low_len - 28'd1);
    assign high_done    = (count_reg == high_len - 28'd1);
    // A halt arriving on the last HIGH clock still stops this cycle.
    assign stop_now     = stop_reg | halt_req;
    assign pend_clamped = (pend_reg < 28'd2) ? 28'd2 : pend_reg;
    assign start_div    = pend_valid_reg ? pend_clamped : div_reg;

    // Step button: two-stage synchronizer followed by a rising-edge register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            step_sync_reg <= 2'b00;
            step_prev_reg <= 1'b0;
        end else begin
            step_sync_reg <= {step_sync_reg[0], step_in};
            step_prev_reg <= step_sync_reg[1];
        end
    end

    // Next-state logic: phase sequencing, divisor hand-over and stop control.
    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        div_next         = div_reg;
        pend_next        = pend_reg;
        pend_valid_next  = pend_valid_reg;
        stop_next        = stop_reg;
        single_next      = single_reg;
        halted_next      = halted_reg;
        phase_read_next  = 1'b0;
        phase_write_next = 1'b0;
        cycle_count_next = cycle_count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (run && !halted_reg) begin
                    state_next      = ST_LOW;
                    count_next      = 28'd0;
                    div_next        = start_div;
                    pend_valid_next = 1'b0;
                    single_next     = 1'b0;
                end else if (step_edge && !run) begin
                    state_next      = ST_LOW;
                    count_next      = 28'd0;
                    div_next        = start_div;
                    pend_valid_next = 1'b0;
                    single_next     = 1'b1;
                end
            end
            ST_LOW: begin
                stop_next = stop_now;
                if (low_done) begin
                    state_next      = ST_HIGH;
                    count_next      = 28'd0;
                    phase_read_next = 1'b1;
                end else begin
                    count_next = count_reg + 28'd1;
                end
            end
            ST_HIGH: begin
                if (high_done) begin
                    phase_write_next = 1'b1;
                    cycle_count_next = cycle_count_reg + 16'd1;
                    if (single_reg || stop_now || !run) begin
                        state_next  = ST_IDLE;
                        stop_next   = 1'b0;
                        halted_next = halted_reg | stop_now;
                    end else begin
                        state_next      = ST_LOW;
                        count_next      = 28'd0;
                        div_next        = start_div;
                        pend_valid_next = 1'b0;
                    end
                end else begin
                    stop_next  = stop_now;
                    count_next = count_reg + 28'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = 28'd0;
            end
        endcase

        // A load lands after any hand-over above, so it waits for the next cycle.
        if (div_load) begin
            pend_next       = div_value;
            pend_valid_next = 1'b1;
        end

        if (!run) begin
            halted_next = 1'b0;
        end

        clock_out_next = (state_next == ST_HIGH);
    end

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            count_reg       <= 28'd0;
            div_reg         <= DIVISOR;
            pend_reg        <= 28'd0;
            pend_valid_reg  <= 1'b0;
            stop_reg        <= 1'b0;
            single_reg      <= 1'b0;
            halted_reg      <= 1'b0;
            clock_out_reg   <= 1'b0;
            phase_read_reg  <= 1'b0;
            phase_write_reg <= 1'b0;
            cycle_count_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            div_reg         <= div_next;
            pend_reg        <= pend_next;
            pend_valid_reg  <= pend_valid_next;
            stop_reg        <= stop_next;
            single_reg      <= single_next;
            halted_reg      <= halted_next;
            clock_out_reg   <= clock_out_next;
            phase_read_reg  <= phase_read_next;
            phase_write_reg <= phase_write_next;
            cycle_count_reg <= cycle_count_next;
        end
    end

    assign clock_out   = clock_out_reg;
    assign phase_read  = phase_read_reg;
    assign phase_write = phase_write_reg;
    assign running     = (state_reg != ST_IDLE);
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_clock_phase_controller.sv
// Bench for clock_phase_controller. A timeline model describes each machine
// cycle by its start edge and divisor; outputs are derived from the offset
// into that cycle and checked on every clock. Literal checks pin the timings.
module tb_clock_phase_controller;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b1;
    logic        run      = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_in  = 1'b0;
    logic        div_load = 1'b0;
    logic [27:0] div_value = 28'd0;
    logic        clock_out, phase_read, phase_write, running;
    logic [15:0] cycle_count;

    always #5 clock_in = ~clock_in;

    clock_phase_controller #(.DIVISOR(28'd10)) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .run         (run),
        .halt_req    (halt_req),
        .step_in     (step_in),
        .div_load    (div_load),
        .div_value   (div_value),
        .clock_out   (clock_out),
        .phase_read  (phase_read),
        .phase_write (phase_write),
        .running     (running),
        .cycle_count (cycle_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Timeline model: edge index k counts rising edges since reset release.
    int  k = 0;
    bit  m_active, m_single, m_stop, m_halted, m_pend_v;
    int  m_s, m_d, m_pend, m_count;
    bit  p1, p2, p3;
    bit  exp_co, exp_pr, exp_pw, exp_run;
    bit  prev_running;
    int  pr_log[$], pw_log[$], rise_log[$], fall_log[$];

    function automatic int clampd(input int x);
        return (x < 2) ? 2 : x;
    endfunction

    task automatic model_reset();
        k = 0; m_active = 0; m_single = 0; m_stop = 0; m_halted = 0;
        m_pend_v = 0; m_pend = 0; m_s = 0; m_d = 10; m_count = 0;
        p1 = 0; p2 = 0; p3 = 0; prev_running = 0;
    endtask

    task automatic start_cycle();
        if (m_pend_v) begin
            m_d = clampd(m_pend);
            m_pend_v = 0;
        end
        m_s = k;
        m_active = 1;
    endtask

    task automatic model_step();
        bit step_edge;
        k++;
        step_edge = p2 && !p3;
        exp_pw = 0;
        if (m_active && halt_req) m_stop = 1;
        if (m_active && (k - m_s) == m_d) begin
            exp_pw = 1;
            m_count = (m_count + 1) % 65536;
            if (m_single || m_stop || !run) begin
                if (m_stop) m_halted = 1;
                m_active = 0;
                m_stop = 0;
            end else begin
                start_cycle();
            end
        end else if (!m_active) begin
            if (run && !m_halted) begin
                start_cycle();
                m_single = 0;
            end else if (step_edge && !run) begin
                start_cycle();
                m_single = 1;
            end
        end
        if (div_load) begin
            m_pend = int'(div_value);
            m_pend_v = 1;
        end
        if (!run) m_halted = 0;
        p3 = p2; p2 = p1; p1 = step_in;
        exp_run = m_active;
        exp_pr  = m_active && ((k - m_s) == m_d / 2);
        exp_co  = m_active && ((k - m_s) >= m_d / 2);
    endtask

    // Per-clock compare process: update the model at the edge, check 1 ns later.
    initial begin
        model_reset();
        forever begin
            @(posedge clock_in);
            if (!reset_n) begin
                model_reset();
            end else begin
                model_step();
                #1;
                chk($sformatf("k%0d clock_out", k), clock_out, exp_co);
                chk($sformatf("k%0d phase_read", k), phase_read, exp_pr);
                chk($sformatf("k%0d phase_write", k), phase_write, exp_pw);
                chk($sformatf("k%0d running", k), running, exp_run);
                chk($sformatf("k%0d cycle_count", k), cycle_count, m_count);
                if (phase_read)  pr_log.push_back(k);
                if (phase_write) pw_log.push_back(k);
                if (running && !prev_running) rise_log.push_back(k);
                if (!running && prev_running) fall_log.push_back(k);
                prev_running = running;
            end
        end
    end

    task automatic wait_k(input int n);
        while (k < n) @(negedge clock_in);
    endtask

    // Asserts reset mid-clock, checks outputs before any edge, releases on a negedge.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        run = 0; halt_req = 0; step_in = 0; div_load = 0; div_value = 0;
        #1;
        chk({tag, " rst clock_out"}, clock_out, 0);
        chk({tag, " rst phase_read"}, phase_read, 0);
        chk({tag, " rst phase_write"}, phase_write, 0);
        chk({tag, " rst running"}, running, 0);
        chk({tag, " rst cycle_count"}, cycle_count, 0);
        @(negedge clock_in);
        @(negedge clock_in);
        pr_log.delete(); pw_log.delete(); rise_log.delete(); fall_log.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Free run with DIVISOR=10: LOW entry at clock 1.
        do_reset("init");
        run = 1;
        wait_k(35);
        chk("free first phase_read", pr_log[0], 6);
        chk("free second phase_read", pr_log[1], 16);
        chk("free third phase_read", pr_log[2], 26);
        chk("free first phase_write", pw_log[0], 11);
        chk("free second phase_write", pw_log[1], 21);
        chk("free count at 35", cycle_count, 3);
        run = 0;
        wait_k(45);
        chk("free stop phase_write", pw_log[3], 41);
        chk("free stop running", running, 0);
        chk("free stop count", cycle_count, 4);

        // Single step: press sampled first at edge 3, LOW entry at edge 5.
        do_reset("step");
        wait_k(2); step_in = 1;
        wait_k(5); step_in = 0;
        wait_k(25);
        chk("step pr count", pr_log.size(), 1);
        chk("step pw count", pw_log.size(), 1);
        chk("step phase_read", pr_log[0], 10);
        chk("step phase_write", pw_log[0], 15);
        chk("step running len", fall_log[0] - rise_log[0], 10);
        chk("step cycle_count", cycle_count, 1);
        chk("step idle", running, 0);

        // Halt two clocks into LOW while run stays high.
        do_reset("halt");
        run = 1;
        wait_k(2); halt_req = 1;
        wait_k(3); halt_req = 0;
        wait_k(30);
        chk("halt pw count", pw_log.size(), 1);
        chk("halt phase_write", pw_log[0], 11);
        chk("halt idle", running, 0);
        chk("halt count", cycle_count, 1);
        run = 0;
        wait_k(32); run = 1;
        wait_k(40);
        chk("halt restart running", running, 1);

        // Divisor 7 loaded mid-HIGH, then 0 and 1 which clamp to 2.
        do_reset("div");
        run = 1;
        wait_k(7);  div_load = 1; div_value = 28'd7;
        wait_k(8);  div_load = 0;
        wait_k(28); div_load = 1; div_value = 28'd0;
        wait_k(29); div_load = 0;
        wait_k(36); div_load = 1; div_value = 28'd1;
        wait_k(37); div_load = 0;
        wait_k(44);
        chk("div old cycle pw", pw_log[0], 11);
        chk("div7 phase_read", pr_log[1], 14);
        chk("div7 phase_write", pw_log[1], 18);
        chk("div0 first pr", pr_log[4], 33);
        chk("div0 first pw", pw_log[4], 34);
        chk("div1 pw", pw_log[8], 42);

        // Async reset in HIGH, then a fresh run uses DIVISOR again.
        do_reset("mid");
        run = 1;
        wait_k(7);
        do_reset("async");
        chk("async no pw", pw_log.size(), 0);
        run = 1;
        wait_k(12);
        chk("async div restored pr", pr_log[0], 6);
        chk("async div restored pw", pw_log[0], 11);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clock_phase_controller.md
# clock_phase_controller

Sequencer for the processor's slow machine clock. Derives the machine-cycle timebase from the 50 MHz board clock with a runtime-loadable divisor, and adds run / halt / single-step control. Produces a 50 % square wave for display plus one-clock `phase_read` / `phase_write` enables, replacing free-running division of `clk_read` / `clk_write`. Sits between the board clock input and the CPU core; the CPU core and the front-panel step button drive it.

## Interface
- `DIVISOR`, 28'd50000000: reset value of the active divisor, in clocks per machine cycle (1 Hz at 50 MHz).
- `clock_in`  in  1  board clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = free-run machine cycles. Synchronous to `clock_in`.
- `halt_req`  in  1  one-clock pulse from the CPU HALT instruction. Synchronous.
- `step_in`  in  1  raw front-panel button, asynchronous; the block synchronizes it.
- `div_load`  in  1  one-clock pulse; captures `div_value`.
- `div_value`  in  28  new divisor.
- `clock_out`  out  1  machine clock, registered; 0 in LOW, 1 in HIGH.
- `phase_read`  out  1  one-clock pulse in the first HIGH clock of each machine cycle.
- `phase_write`  out  1  one-clock pulse in the first clock after each HIGH phase ends.
- `running`  out  1  1 when state ≠ IDLE.
- `cycle_count`  out  16  completed machine cycles; wraps 0xFFFF→0.

## Operation
- **Reset values** (async, while `reset_n`=0):
  - state IDLE; counter 0; active divisor D = DIVISOR; pending divisor invalid.
  - `clock_out`, `phase_read`, `phase_write` = 0; `cycle_count` = 0.
  - step synchronizer and edge register = 0; `stop_pending` = 0; `single` = 0.
- **Divisor**:
  - `div_load` stores `div_value` as pending; a later load overwrites it.
  - Pending is copied to D only when a machine cycle starts (entry to LOW at counter 0, from IDLE or HIGH).
  - Values < 2 are clamped to 2.
  - LOW length L = floor(D/2); HIGH length H = D − L. Odd D gives the longer HIGH.
- **Step input**: 2-FF synchronizer, then a rising-edge detector; one `step_edge` pulse per press.
  - The edge is ignored unless state = IDLE and `run` = 0.
  - No debounce; bounce gives extra steps by design.
- **FSM** (28-bit counter):
  - IDLE:
    - `run`=1 → LOW, `single`=0.
    - Else `step_edge` → LOW, `single`=1.
    - `run` has priority over a simultaneous step.
  - LOW: counter runs 0..L−1; at L−1 → HIGH with counter reset to 0, and `phase_read` set for the next clock.
  - HIGH: counter runs 0..H−1; at H−1:
    - `phase_write` set for the next clock; `cycle_count` += 1.
    - If `single`, or `stop_pending`, or `run`=0 → IDLE and clear `stop_pending`.
    - Otherwise → LOW with counter 0.
- **Stopping**:
  - `halt_req` in LOW or HIGH sets `stop_pending`; in IDLE it has no effect.
  - Any stop takes effect only at the end of HIGH. A started machine cycle always completes with both phases.
- **Divisor change**: `div_load` during a cycle never alters that cycle's L/H.

## Timing
- `clock_out` = 1 exactly while state = HIGH. It is a registered state bit, so glitch-free.
- Free run, steady state: period D clocks.
  - `clock_out` low for L clocks, then high for H clocks.
  - `phase_read` and `phase_write` each high 1 clock per period, L and D clocks after LOW entry.
- IDLE→LOW with `run`: one clock after `run` is sampled 1.
- Step: LOW is entered on the 3rd rising edge at or after the first edge sampling `step_in`=1.
- Single step from LOW entry:
  - `phase_read` after L clocks; `phase_write` after D clocks, coinciding with return to IDLE.
  - `running` falls in the same clock as `phase_write`.
- `halt_req` and `div_load` in the same clock: both are honoured.
- `reset_n` low mid-cycle: outputs reach their reset values immediately. No `phase_write` is emitted for the aborted cycle.

## Test plan
- DIVISOR=10, `run`=1 after reset:
  - `clock_out` low 5 / high 5.
  - `phase_read` at clocks 6, 16, 26…; `phase_write` at clocks 11, 21…, counted from LOW entry at clock 1.
  - `cycle_count` increments by 1 per `phase_write`.
- `run`=0, one `step_in` press → exactly one `phase_read` and one `phase_write`; `running` high for 10 clocks; `cycle_count`=1; state IDLE.
- `halt_req` pulsed 2 clocks into LOW while `run`=1 → cycle completes (`phase_read`, then `phase_write`) → IDLE; `run` still 1 does not restart it.
- `div_load` with 7 mid-HIGH → current cycle stays 10 clocks; the next is 3 low / 4 high.
- `div_load` with 0 and 1 → D clamps to 2 (1 low / 1 high).
- Async reset asserted in HIGH → all outputs 0 before the next clock edge, D = DIVISOR, no `phase_write`.
